// File: rtl/bsram_stream_reader_pkg.sv
// Shared types and sizing helpers for the bsram burst stream reader.
package bsram_stream_reader_pkg;

  localparam int DATA_ADDR_WIDTH = 8;
  localparam int WORD_WIDTH      = 16;

  // One FIFO entry: the memory word plus its end-of-burst tag.
  typedef struct packed {
    logic                  last;
    logic [WORD_WIDTH-1:0] data;
  } beat_t;

  // Two slots beyond the read latency let reads keep issuing while the
  // consumer takes one word per cycle.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous first-word-fall-through FIFO; only pointers and count are reset.
module stream_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // The issuer's credit accounting must never let a push meet a full FIFO.
  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/bsram_stream_reader.sv
// Sequential burst reader: issues consecutive bsram reads and presents the
// returned words as a valid/ready stream with an end-of-burst marker.
module bsram_stream_reader
  import bsram_stream_reader_pkg::*;
#(
  parameter int WIDTH      = DATA_ADDR_WIDTH,
  parameter int LEN_WIDTH  = WIDTH + 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      mem_dout_addr,
  input  logic [15:0]           mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_data,
  output logic                  out_last
);

  localparam int DEPTH = fifo_depth(RD_LATENCY);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [RD_LATENCY-1:0] rd_last_q, rd_last_d;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           inflight, occupancy;
  logic                  fifo_full, fifo_empty;
  logic                  issue_en, xfer;
  beat_t                 push_beat, head_beat;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (CW+1)'(rd_vld_q[i]);
  end

  // Credit uses registered counts only, so out_ready never reaches the address path.
  assign occupancy = (CW+1)'(fifo_count) + inflight;
  assign issue_en  = (state_q == ISSUE) && !fifo_full && (occupancy < (CW+1)'(DEPTH));

  assign rd_vld_d  = (rd_vld_q << 1) | RD_LATENCY'(issue_en);
  assign rd_last_d = (rd_last_q << 1) | RD_LATENCY'(issue_en && (issue_left_q == LEN_WIDTH'(1)));

  assign push_beat = '{last: rd_last_q[RD_LATENCY-1], data: mem_dout};
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beats_left_d = xfer ? beats_left_q - 1'b1 : beats_left_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          issue_left_d = length;
          beats_left_d = length;
          if (length != '0) begin
            addr_d  = start_addr;
            state_d = ISSUE;
          end else begin
            state_d = FIN;
          end
        end
      end
      ISSUE: begin
        if (issue_en) begin
          addr_d       = addr_q + 1'b1;
          issue_left_d = issue_left_q - 1'b1;
          if (issue_left_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      // The final beat leaving empties both FIFO and read pipe, so finish on it.
      DRAIN: begin
        if (xfer && beats_left_q == LEN_WIDTH'(1)) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      rd_vld_q     <= '0;
      rd_last_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
    end
  end

  stream_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_vld_q[RD_LATENCY-1]),
    .push_data (push_beat),
    .pop       (xfer),
    .pop_data  (head_beat),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid     = ~fifo_empty;
  assign out_data      = out_valid ? head_beat.data : '0;
  assign out_last      = out_valid & head_beat.last;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign mem_dout_addr = addr_q;

endmodule

// File: tb/tb_bsram_stream_reader.sv
// Runs two readers (read latency 1 and 2) on shared stimulus against a burst-level model.
module tb_bsram_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [8:0]  length = '0;
  logic        out_ready = 1'b1;
  int          ready_mode = 0;

  logic [1:0]  busy_w, done_w, out_valid_w, out_last_w;
  logic [15:0] out_data_w [2];
  logic [7:0]  addr_w [2];
  logic [15:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Burst-level model state, one slot per instance.
  logic [16:0] exp_q [2][$];
  logic [15:0] log_q [2][$];
  bit          m_busy [2], m_done [2], m_stall [2], m_after_rst [2];
  bit          m_seen_first [2], m_all_ready [2];
  logic [16:0] m_hold [2];
  int          m_acc [2], first_lat [2], done_lat [2];
  bit          nb, nd;
  logic [16:0] exp_beat;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] rd1, rd2, mem_dout;
    always @(posedge clk) begin
      rd1 <= mem[addr_w[gi]];
      rd2 <= rd1;
    end
    assign mem_dout = (gi == 0) ? rd1 : rd2;

    bsram_stream_reader #(
      .WIDTH      (8),
      .LEN_WIDTH  (9),
      .RD_LATENCY (gi + 1)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .start_addr    (start_addr),
      .length        (length),
      .busy          (busy_w[gi]),
      .done          (done_w[gi]),
      .mem_dout_addr (addr_w[gi]),
      .mem_dout      (mem_dout),
      .out_valid     (out_valid_w[gi]),
      .out_ready     (out_ready),
      .out_data      (out_data_w[gi]),
      .out_last      (out_last_w[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  int rcyc = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rcyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    rcyc++;
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_done[k] = 0; m_stall[k] = 0; m_after_rst[k] = 1;
        exp_q[k].delete();
        continue;
      end
      if (m_after_rst[k]) begin
        check($sformatf("post_reset_zero%0d", k),
              {busy_w[k], done_w[k], out_valid_w[k], out_last_w[k], out_data_w[k], addr_w[k]}, 0);
        m_after_rst[k] = 0;
      end
      check($sformatf("busy%0d", k), busy_w[k], m_busy[k]);
      check($sformatf("done%0d", k), done_w[k], m_done[k]);
      if (!out_valid_w[k]) check($sformatf("idle_zero%0d", k), {out_last_w[k], out_data_w[k]}, 0);
      if (exp_q[k].size() == 0) check($sformatf("no_extra_beat%0d", k), out_valid_w[k], 0);
      if (m_stall[k]) check($sformatf("hold%0d", k), {out_valid_w[k], out_last_w[k], out_data_w[k]}, {1'b1, m_hold[k]});
      if (out_valid_w[k] && !m_seen_first[k] && exp_q[k].size() > 0) begin
        first_lat[k] = cyc - m_acc[k];
        check($sformatf("first_latency%0d", k), first_lat[k], k + 3);
        m_seen_first[k] = 1;
      end
      if (m_all_ready[k] && m_seen_first[k] && exp_q[k].size() > 0)
        check($sformatf("throughput%0d", k), out_valid_w[k], 1);

      nb = m_done[k] ? 1'b0 : m_busy[k];
      nd = 1'b0;
      if (out_valid_w[k] && out_ready && exp_q[k].size() > 0) begin
        exp_beat = exp_q[k].pop_front();
        check($sformatf("beat%0d", k), {out_last_w[k], out_data_w[k]}, exp_beat);
        log_q[k].push_back(out_data_w[k]);
        if (exp_q[k].size() == 0) begin
          nd = 1'b1;
          done_lat[k] = cyc + 1 - m_acc[k];
        end
      end
      if (!m_busy[k] && start) begin
        nb = 1'b1;
        m_acc[k] = cyc;
        m_seen_first[k] = 0;
        m_all_ready[k] = 1;
        if (length == 0) begin
          nd = 1'b1;
          done_lat[k] = 1;
        end else begin
          for (int i = 0; i < int'(length); i++)
            exp_q[k].push_back({(i == int'(length) - 1), mem[8'(start_addr + 8'(i))]});
        end
      end
      if (m_busy[k] && !out_ready) m_all_ready[k] = 0;
      m_stall[k] = out_valid_w[k] & ~out_ready;
      m_hold[k]  = {out_last_w[k], out_data_w[k]};
      m_busy[k]  = nb;
      m_done[k]  = nd;
    end
  end

  task automatic start_burst(input logic [7:0] a, input logic [8:0] n);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy[0] || m_busy[1] || busy_w != 2'b00) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 300, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_q[0].delete();
    log_q[1].delete();
  endtask

  task automatic check_seq(input string name, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_count%0d", name, k), log_q[k].size(), 4);
      for (int i = 0; i < 4; i++)
        if (i < log_q[k].size()) check($sformatf("%s_word%0d_%0d", name, k, i), log_q[k][i], w[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {8'(a) ^ 8'h3C, 8'($urandom)};
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 16'hA0A0 + 16'(i);
    mem[8'hFE] = 16'hB0B0; mem[8'hFF] = 16'hB1B1;
    mem[8'h00] = 16'hB2B2; mem[8'h01] = 16'hB3B3;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Straight burst with the consumer always ready.
    ready_mode = 0;
    clear_logs();
    start_burst(8'h10, 9'd4);
    wait_idle();
    check_seq("t1", 16'hA0A0, 16'hA0A1, 16'hA0A2, 16'hA0A3);
    check("t1_first_lat0", first_lat[0], 3);
    check("t1_first_lat1", first_lat[1], 4);
    check("t1_done_lat0", done_lat[0], 7);
    check("t1_done_lat1", done_lat[1], 8);

    // Same burst under a 1,0,0 ready pattern.
    ready_mode = 1;
    clear_logs();
    start_burst(8'h10, 9'd4);
    wait_idle();
    check_seq("t2", 16'hA0A0, 16'hA0A1, 16'hA0A2, 16'hA0A3);

    // Zero-length burst leaves the read address alone.
    ready_mode = 0;
    start_burst(8'h55, 9'd0);
    wait_idle();
    check("t3_addr0", addr_w[0], 8'h14);
    check("t3_addr1", addr_w[1], 8'h14);
    check("t3_done_lat0", done_lat[0], 1);

    // Address wrap at the top of memory.
    clear_logs();
    start_burst(8'hFE, 9'd4);
    wait_idle();
    check_seq("t4", 16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3);

    // Reset in the middle of a burst, then a clean burst.
    ready_mode = 2;
    start_burst(8'h20, 9'd8);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ready_mode = 0;
    clear_logs();
    start_burst(8'h10, 9'd4);
    wait_idle();
    check_seq("t5", 16'hA0A0, 16'hA0A1, 16'hA0A2, 16'hA0A3);

    // A second start while busy must be dropped.
    clear_logs();
    start_burst(8'h10, 9'd4);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 8'h40; length = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check_seq("t6", 16'hA0A0, 16'hA0A1, 16'hA0A2, 16'hA0A3);

    // Randomized starts, lengths, backpressure and occasional resets.
    ready_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      reset      = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 5) == 0);
      start_addr = 8'($urandom);
      length     = 9'($urandom_range(0, 12));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
